// File: rtl/ground_pkg.sv
// Shared constants, types and tile artwork for the scrolling-ground renderer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ground_pkg;

  localparam int TILE_W     = 40;
  localparam int TILE_COUNT = 16;
  localparam int GROUND_Y   = 400;
  localparam int GROUND_H   = 8;
  localparam int SCREEN_W   = 640;
  localparam int POS_W      = 6;

  typedef logic [5:0] tile_col_t;
  typedef logic [2:0] tile_row_t;
  typedef logic [3:0] tile_idx_t;

  // Flat tile: a solid top edge with a few pebbles scattered below it.
  function automatic logic [TILE_W-1:0] flat_mask(input tile_row_t row);
    logic [TILE_W-1:0] m;
    m = '0;
    case (row)
      3'd0: m = '1;
      3'd1: begin m[7] = 1'b1; m[23] = 1'b1; end
      3'd2: begin m[15] = 1'b1; m[31] = 1'b1; end
      3'd3: m[3] = 1'b1;
      3'd4: m[27] = 1'b1;
      3'd5: m[11] = 1'b1;
      3'd6: m[35] = 1'b1;
      3'd7: begin m[19] = 1'b1; m[38] = 1'b1; end
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ground_tile_rom.sv
// Tile ROM: combinational (pattern, row, col) -> ground bit; pattern 1 adds a bump.
// Latency: 0 cycles (pure combinational lookup).
// Backpressure: none; the lookup is evaluated every cycle.
module ground_tile_rom
  import ground_pkg::*;
(
  input  logic      pattern,
  input  tile_row_t row,
  input  tile_col_t col,
  output logic      pix_bit
);

  logic [TILE_W-1:0] mask;
  logic              bump;

  // Look up the flat artwork and overlay the raised block for the bump set.
  always_comb begin
    mask    = flat_mask(row);
    bump    = pattern && (row <= 3'd2) && (col >= 6'd10) && (col <= 6'd19);
    pix_bit = 1'b0;
    if (col < 6'(TILE_W)) begin
      pix_bit = mask[col] | bump;
    end
  end

endmodule

// File: rtl/ground_renderer.sv
// Ground band renderer: scroll-shifted 40 px tiles; GROUND_BUMPS_EN selects bumps on odd tiles.
// Latency: 2 cycles pix_valid -> ground_valid, one pixel per cycle.
// Backpressure: none; the pixel stream is never stalled.
module ground_renderer
  import ground_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             frame_start,
  input  logic [POS_W-1:0] ground_position,
  input  logic             pix_valid,
  input  logic [9:0]       pix_x,
  input  logic [9:0]       pix_y,
  output logic             ground_pixel,
  output logic             ground_valid
);

  logic [POS_W-1:0] pos_latched;
  logic [POS_W-1:0] pos_wrapped;
  tile_col_t        col_cnt;
  tile_idx_t        tile_idx;
  logic             in_band;
  logic             s1_vld;
  logic             s1_in_band;
  tile_row_t        s1_row;
  logic             pattern;
  logic             rom_bit;

  // Fold out-of-range scroll values back into 0..39 and classify the row.
  always_comb begin
    pos_wrapped = ground_position;
    if (ground_position >= POS_W'(TILE_W)) begin
      pos_wrapped = ground_position - POS_W'(TILE_W);
    end
    in_band = (pix_y >= 10'(GROUND_Y)) && (pix_y < 10'(GROUND_Y + GROUND_H));
  end

  // Stage 1: frame-synchronous position latch, column/tile tracking, band info.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pos_latched <= '0;
      col_cnt     <= '0;
      tile_idx    <= '0;
      s1_vld      <= 1'b0;
      s1_in_band  <= 1'b0;
      s1_row      <= '0;
    end else begin
      if (frame_start) begin
        pos_latched <= pos_wrapped;
      end
      s1_vld     <= pix_valid;
      s1_in_band <= in_band;
      s1_row     <= tile_row_t'(pix_y[2:0] - 3'(GROUND_Y));
      if (pix_valid) begin
        if (pix_x == 10'd0) begin
          col_cnt  <= pos_latched;
          tile_idx <= '0;
        end else if (col_cnt == 6'(TILE_W - 1)) begin
          col_cnt <= '0;
          if (tile_idx != 4'(TILE_COUNT - 1)) begin
            tile_idx <= tile_idx + 4'd1;
          end
        end else begin
          col_cnt <= col_cnt + 6'd1;
        end
      end
    end
  end

`ifdef GROUND_BUMPS_EN
  assign pattern = tile_idx[0];
`else
  assign pattern = 1'b0;
`endif

  ground_tile_rom u_rom (
    .pattern (pattern),
    .row     (s1_row),
    .col     (col_cnt),
    .pix_bit (rom_bit)
  );

  // Stage 2: register the final pixel, masked outside the band and when invalid.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ground_valid <= 1'b0;
      ground_pixel <= 1'b0;
    end else begin
      ground_valid <= s1_vld;
      ground_pixel <= s1_vld & s1_in_band & rom_bit;
    end
  end

endmodule

// File: tb/tb_ground_renderer.sv
// Self-checking bench for ground_renderer (default build, flat tiles only).
// Latency: checks the 2-cycle pipeline alignment on every cycle.
// Backpressure: none exercised; the stream is free-running.
module tb_ground_renderer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       frame_start;
  logic [5:0] ground_position;
  logic       pix_valid;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       ground_pixel;
  logic       ground_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state derived from the behavioural description.
  int   m_pos = 0;
  int   m_col = 0;
  logic exp_v_prev = 1'b0;
  logic exp_p_prev = 1'b0;

  typedef struct {
    logic [5:0] gp;
    int         y;
    int         x;
    logic       exp;
  } vec_t;

  vec_t vecs[12];

  always #5 CLK = ~CLK;

  ground_renderer dut (
    .CLK             (CLK),
    .RST             (RST),
    .frame_start     (frame_start),
    .ground_position (ground_position),
    .pix_valid       (pix_valid),
    .pix_x           (pix_x),
    .pix_y           (pix_y),
    .ground_pixel    (ground_pixel),
    .ground_valid    (ground_valid)
  );

  function automatic logic rom_model(input int r, input int c);
    case (r)
      0: return 1'b1;
      1: return (c == 7) || (c == 23);
      2: return (c == 15) || (c == 31);
      3: return (c == 3);
      4: return (c == 27);
      5: return (c == 11);
      6: return (c == 35);
      7: return (c == 19) || (c == 38);
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the clock, and compare the outputs
  // belonging to the previous call against the reference model.
  task automatic drive(input logic rst, input logic fs, input logic [5:0] gp,
                       input logic pv, input int x, input int y);
    logic ev;
    logic ep;
    RST             = rst;
    frame_start     = fs;
    ground_position = gp;
    pix_valid       = pv;
    pix_x           = 10'(x);
    pix_y           = 10'(y);
    ev = 1'b0;
    ep = 1'b0;
    if (rst) begin
      m_pos = 0;
      m_col = 0;
    end else begin
      if (pv) begin
        if (x == 0) m_col = m_pos;
        else        m_col = (m_col == 39) ? 0 : m_col + 1;
        ev = 1'b1;
        ep = (y >= 400 && y < 408) ? rom_model(y - 400, m_col) : 1'b0;
      end
      if (fs) m_pos = (gp >= 40) ? int'(gp) - 40 : int'(gp);
    end
    @(posedge CLK);
    #1;
    if (rst) begin
      exp_v_prev = 1'b0;
      exp_p_prev = 1'b0;
    end
    check("stream_valid", ground_valid, exp_v_prev);
    check("stream_pixel", ground_pixel, exp_p_prev);
    exp_v_prev = ev;
    exp_p_prev = ep;
  endtask

  task automatic run_line(input logic [5:0] gp, input int y, input int x0, input int x1);
    for (int x = x0; x <= x1; x++) drive(1'b0, 1'b0, gp, 1'b1, x, y);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, ground_position, 1'b0, 0, 0);
  endtask

  initial begin
    // {ground_position at frame_start, pix_y, probed pix_x, expected bit}
    vecs[0]  = '{6'd0,  400, 100, 1'b1};  // row 0 solid
    vecs[1]  = '{6'd0,  399, 5,   1'b0};  // just above band
    vecs[2]  = '{6'd0,  408, 5,   1'b0};  // just below band
    vecs[3]  = '{6'd5,  401, 2,   1'b1};  // col 7 pebble
    vecs[4]  = '{6'd5,  401, 3,   1'b0};  // col 8 empty
    vecs[5]  = '{6'd47, 401, 0,   1'b1};  // 47 -> 7, col 7
    vecs[6]  = '{6'd47, 401, 16,  1'b1};  // col 23
    vecs[7]  = '{6'd63, 407, 36,  1'b1};  // 63 -> 23, col 19, row 7
    vecs[8]  = '{6'd39, 403, 4,   1'b1};  // wrap to col 3
    vecs[9]  = '{6'd0,  406, 75,  1'b1};  // col 35 second tile
    vecs[10] = '{6'd40, 404, 27,  1'b1};  // 40 -> 0, col 27
    vecs[11] = '{6'd10, 405, 639, 1'b0};  // last pixel, col 9

    RST = 1'b1; frame_start = 1'b0; ground_position = '0;
    pix_valid = 1'b0; pix_x = '0; pix_y = '0;

    drive(1'b1, 1'b0, 6'd0, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 6'd0, 1'b0, 0, 0);
    check("reset_valid", ground_valid, 1'b0);
    check("reset_pixel", ground_pixel, 1'b0);

    // Full ground row at position 0, then a shifted pebble row.
    drive(1'b0, 1'b1, 6'd0, 1'b0, 0, 0);
    run_line(6'd0, 400, 0, 639);
    idle(2);
    drive(1'b0, 1'b1, 6'd5, 1'b0, 0, 0);
    run_line(6'd5, 401, 0, 639);
    idle(2);

    // Directed vector table.
    foreach (vecs[i]) begin
      drive(1'b0, 1'b1, vecs[i].gp, 1'b0, 0, 0);
      run_line(vecs[i].gp, vecs[i].y, 0, vecs[i].x);
      drive(1'b0, 1'b0, vecs[i].gp, 1'b0, 0, 0);
      check($sformatf("vec%0d_valid", i), ground_valid, 1'b1);
      check($sformatf("vec%0d_pixel", i), ground_pixel, vecs[i].exp);
      idle(1);
    end

    // Mid-frame position change is ignored (latched value stays 7).
    drive(1'b0, 1'b1, 6'd47, 1'b0, 0, 0);
    run_line(6'd20, 401, 0, 639);
    drive(1'b0, 1'b0, 6'd20, 1'b1, 0, 401);
    drive(1'b0, 1'b0, 6'd20, 1'b0, 0, 0);
    check("no_tearing_pixel", ground_pixel, 1'b1);
    idle(2);

    // frame_start coincident with x=0: that pixel still uses position 7.
    drive(1'b0, 1'b1, 6'd3, 1'b1, 0, 401);
    drive(1'b0, 1'b0, 6'd3, 1'b1, 1, 401);
    check("fs_same_cycle_pixel", ground_pixel, 1'b1);
    run_line(6'd3, 401, 2, 639);
    run_line(6'd3, 401, 0, 4);
    drive(1'b0, 1'b0, 6'd3, 1'b0, 0, 0);
    check("fs_next_line_pixel", ground_pixel, 1'b1);
    idle(2);

    // Gap in pix_valid holds the column count.
    run_line(6'd3, 401, 0, 5);
    idle(3);
    run_line(6'd3, 401, 6, 40);
    idle(2);

    // Reset mid-line, then first pixel after release uses position 0.
    run_line(6'd3, 400, 0, 299);
    drive(1'b1, 1'b0, 6'd3, 1'b1, 300, 400);
    check("midline_rst_valid", ground_valid, 1'b0);
    check("midline_rst_pixel", ground_pixel, 1'b0);
    drive(1'b0, 1'b0, 6'd3, 1'b0, 0, 0);
    check("post_rst_flush_valid", ground_valid, 1'b0);
    run_line(6'd3, 401, 0, 7);
    drive(1'b0, 1'b0, 6'd3, 1'b0, 0, 0);
    check("post_rst_pos0_pixel", ground_pixel, 1'b1);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
